// File: rtl/alu_chunked.sv
// Multi-cycle ALU: evaluates a WIDTH-bit op CHUNK bits per clock with a registered carry.
// Optional macro ALU_FLAGS_EN registers zero/carry/overflow flags; when undefined the flag outputs are tied low.
module alu_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a transfer happens on an edge where valid && ready; in_ready is high
  // only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [3:0]        r_op;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_work;
  logic [WIDTH-1:0]  r_result;

  logic              w_accept;
  logic              w_last;
  logic              w_sub_in;
  logic [CHUNK-1:0]  w_a_ch;
  logic [CHUNK-1:0]  w_b_ch;
  logic [CHUNK:0]    w_add;
  logic              w_cout;
  logic              w_cin_msb;
  logic              w_ovf;
  logic [CHUNK-1:0]  w_chunk_val;
  logic [WIDTH-1:0]  w_work_next;
  logic [WIDTH-1:0]  w_final;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign o_dbg_state = r_state;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == S_BUSY) && (r_idx == IDXW'(N - 1));
  assign w_sub_in = (op == OP_SUB) || (op == OP_SLT);

  assign w_a_ch    = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_ch    = r_b[r_idx*CHUNK +: CHUNK];
  assign w_add     = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
  assign w_cout    = w_add[CHUNK];
  // Sum MSB is a ^ b ^ carry-in, so the carry into the top bit falls out by re-xoring.
  assign w_cin_msb = w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1] ^ w_add[CHUNK-1];
  assign w_ovf     = w_cin_msb ^ w_cout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_BUSY;
      S_BUSY: if (w_last) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_chunk_val = '0;
    case (r_op)
      OP_AND:                 w_chunk_val = w_a_ch & w_b_ch;
      OP_OR:                  w_chunk_val = w_a_ch | w_b_ch;
      OP_XOR:                 w_chunk_val = w_a_ch ^ w_b_ch;
      OP_NOR:                 w_chunk_val = ~(w_a_ch | w_b_ch);
      OP_ADD, OP_SUB, OP_SLT: w_chunk_val = w_add[CHUNK-1:0];
      default:                w_chunk_val = '0;
    endcase
  end

  always_comb begin
    w_work_next = r_work;
    w_work_next[r_idx*CHUNK +: CHUNK] = w_chunk_val;
  end

  always_comb begin
    w_final = w_work_next;
    if (r_op == OP_SLT) w_final = {{(WIDTH-1){1'b0}}, w_work_next[WIDTH-1] ^ w_ovf};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_work   <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_sub_in ? ~b : b;
      r_op    <= op;
      r_carry <= w_sub_in;
      r_idx   <= '0;
    end else if (r_state == S_BUSY) begin
      r_work  <= w_work_next;
      r_carry <= w_cout;
      if (w_last) begin
        r_idx    <= '0;
        r_result <= w_final;
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic r_zero;
  logic r_cflag;
  logic r_oflag;
  logic w_arith;
  logic w_legal;

  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_legal = w_arith || (r_op == OP_AND) || (r_op == OP_OR) ||
                   (r_op == OP_XOR) || (r_op == OP_NOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero  <= 1'b0;
      r_cflag <= 1'b0;
      r_oflag <= 1'b0;
    end else if (w_last) begin
      r_zero  <= w_legal && (w_final == '0);
      r_cflag <= w_arith && w_cout;
      r_oflag <= w_arith && w_ovf;
    end
  end

  assign flag_zero  = r_zero;
  assign flag_carry = r_cflag;
  assign flag_ovf   = r_oflag;
`else
  assign flag_zero  = 1'b0;
  assign flag_carry = 1'b0;
  assign flag_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_chunked.sv
// Bench for alu_chunked: an N=4 (CHUNK=2) and an N=1 (CHUNK=8) instance driven in lockstep, checked against a full-width model.
module tb_alu_chunked;
  localparam int W = 8;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;

  logic         in_ready0, out_valid0, fz0, fc0, fv0;
  logic [W-1:0] result0;
  logic [1:0]   st0;
  logic         in_ready1, out_valid1, fz1, fc1, fv1;
  logic [W-1:0] result1;
  logic [1:0]   st1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+2:0] exp_q[$];

  always #5 clk = ~clk;

  alu_chunked #(.WIDTH(W), .CHUNK(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .flag_zero(fz0), .flag_carry(fc0), .flag_ovf(fv0),
    .o_dbg_state(st0)
  );

  alu_chunked #(.WIDTH(W), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .flag_zero(fz1), .flag_carry(fc1), .flag_ovf(fv1),
    .o_dbg_state(st1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns {result, zero, carry, ovf} from plain full-width arithmetic.
  function automatic logic [W+2:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic [W-1:0] d;
    logic         c, v, legal;
    r = '0; c = 1'b0; v = 1'b0; legal = 1'b1;
    case (o)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_NOR: r = ~(x | y);
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      OP_SUB, OP_SLT: begin
        d = x - y;
        c = (x >= y);
        v = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
        if (o == OP_SUB) r = d;
        else             r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      end
      default: legal = 1'b0;
    endcase
    return {r, legal && (r == '0), c, v};
  endfunction

  function automatic logic [2:0] exp_flags(input logic [W+2:0] e);
`ifdef ALU_FLAGS_EN
    return e[2:0];
`else
    return (e[2:0] & 3'b000);
`endif
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    logic [W+2:0] e;
    int k, lat0, lat1;
    @(negedge clk);
    check("idle_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
    in_valid = 1'b1; a = x; b = y; op = o;
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
    check("busy_ready", {31'd0, in_ready0}, 32'd0);
    k = 0; lat0 = -1; lat1 = -1;
    while (k < 20) begin
      if (out_valid0 && lat0 < 0) lat0 = k;
      if (out_valid1 && lat1 < 0) lat1 = k;
      if (lat0 >= 0 && lat1 >= 0) break;
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      k++;
    end
    check("latency_n4", lat0, 4);
    check("latency_n1", lat1, 1);
    e = exp_q.pop_front();
    check("result_n4", {24'd0, result0}, {24'd0, e[W+2:3]});
    check("flags_n4", {29'd0, fz0, fc0, fv0}, {29'd0, exp_flags(e)});
    check("result_n1", {24'd0, result1}, {24'd0, e[W+2:3]});
    check("flags_n1", {29'd0, fz1, fc1, fv1}, {29'd0, exp_flags(e)});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      @(negedge clk);
      check("hold_result", {24'd0, result0}, {24'd0, e[W+2:3]});
      check("hold_valid", {30'd0, out_valid1, out_valid0}, 32'd3);
      check("hold_ready", {30'd0, in_ready1, in_ready0}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release", {28'd0, in_ready0, out_valid0, in_ready1, out_valid1}, 32'b1010);
  endtask

  initial begin
    logic [3:0] legal_ops [8];
    legal_ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SLT, OP_NOR, 4'b0011};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
    check("rst_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
    check("rst_result", {16'd0, result1, result0}, 32'd0);
    check("rst_flags", {26'd0, fz0, fc0, fv0, fz1, fc1, fv1}, 32'd0);
    check("rst_state", {28'd0, st1, st0}, 32'd0);
    rst = 1'b0;

    run_op(OP_ADD, 8'h7F, 8'h01, 0);
    run_op(OP_ADD, 8'hFF, 8'h01, 0);
    run_op(OP_SUB, 8'h05, 8'h07, 0);
    run_op(OP_SLT, 8'h80, 8'h01, 0);
    run_op(OP_SLT, 8'h01, 8'h80, 0);
    run_op(OP_AND, 8'hCA, 8'h0F, 0);
    run_op(OP_OR,  8'hCA, 8'h0F, 0);
    run_op(OP_XOR, 8'hCA, 8'h0F, 0);
    run_op(OP_NOR, 8'hCA, 8'h0F, 10);
    run_op(4'b0011, 8'hCA, 8'h0F, 0);

    // Reset held two cycles while the N=4 instance is mid-operation.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h03; b = 8'h04; op = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
    check("midrst_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
    check("midrst_result", {16'd0, result1, result0}, 32'd0);
    check("midrst_flags", {26'd0, fz0, fc0, fv0, fz1, fc1, fv1}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_partial", {30'd0, out_valid1, out_valid0}, 32'd0);
    end
    run_op(OP_ADD, 8'h03, 8'h04, 2);

    for (int i = 0; i < 40; i++) begin
      run_op(legal_ops[$urandom_range(0, 7)], W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 8; i++) begin
      run_op(4'($urandom), W'($urandom), W'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
